// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial packed-BCD adder: one shared single-digit BCD stage walks LSD->MSD.
// Latency: accept edge E0, digits on E1..E_DIGITS, out_valid after E_DIGITS+1.
// Backpressure: result held in DONE until out_ready; in_ready low while RUN/DONE.
// Optional BCD_SUB_EN macro adds a sub port (9's-complement B, carry-in forced to 1).
module bcd_serial_add_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   op_a,
  input  logic [4*DIGITS-1:0]   op_b,
  input  logic                  cin,
`ifdef BCD_SUB_EN
  input  logic                  sub,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  err,
  output logic                  busy
);

  localparam int W  = 4 * DIGITS;
  localparam int KW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic            c_q, c_d;
  logic            cout_q, cout_d;
  logic            err_q, err_d;
  logic            out_valid_q, out_valid_d;
  logic            in_ready_q, in_ready_d;
  logic            busy_q, busy_d;
`ifdef BCD_SUB_EN
  logic            sub_q, sub_d;
`endif

  // Shared digit stage: operands shift right so the active digit is always at [3:0].
  logic [3:0] b_dig;
  logic [4:0] t;
  logic       carry;
  logic [3:0] digit;

  // Single-digit BCD add with decimal correction; invalid digits use the same rule.
  always_comb begin
    b_dig = b_q[3:0];
`ifdef BCD_SUB_EN
    if (sub_q) b_dig = 4'd9 - b_q[3:0];
`endif
    t     = {1'b0, a_q[3:0]} + {1'b0, b_dig} + {4'b0000, c_q};
    carry = (t > 5'd9);
    digit = carry ? (t[3:0] + 4'd6) : t[3:0];
  end

  // Next-state and next-register values; every target defaults to holding.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    err_d   = err_q;
`ifdef BCD_SUB_EN
    sub_d   = sub_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d    = op_a;
          b_d    = op_b;
          c_d    = cin;
`ifdef BCD_SUB_EN
          sub_d  = sub;
          if (sub) c_d = 1'b1;
`endif
          k_d     = '0;
          err_d   = 1'b0;
          sum_d   = '0;
          cout_d  = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = a_q >> 4;
        b_d   = b_q >> 4;
        c_d   = carry;
        // New digit enters at the top; after DIGITS shifts digit 0 sits at [3:0].
        sum_d = (sum_q >> 4) | (W'(digit) << (W - 4));
        err_d = err_q | (a_q[3:0] > 4'd9) | (b_q[3:0] > 4'd9);
        k_d   = k_q + KW'(1);
        if (k_q == KW'(DIGITS - 1)) begin
          cout_d  = carry;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_valid_q && out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // out_valid rises one cycle into DONE, so the result settles before it is offered.
    out_valid_d = (state_q == DONE) && (state_d == DONE);
    in_ready_d  = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_q         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
`ifdef BCD_SUB_EN
      sub_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
`ifdef BCD_SUB_EN
      sub_q       <= sub_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign err       = err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Self-checking bench for bcd_serial_add_ctrl (DIGITS=4): vector table,
// hand-written backpressure/reset sequences, and random ops vs a decimal model.
module tb_bcd_serial_add_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] op_a = '0;
  logic [15:0] op_b = '0;
  logic        cin = 1'b0;
`ifdef BCD_SUB_EN
  logic        sub = 1'b0;
`endif
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] sum;
  logic        cout;
  logic        err;
  logic        busy;

  int cmps  = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bcd_serial_add_ctrl #(.DIGITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .cin(cin),
`ifdef BCD_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout),
    .err(err), .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmps++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int x;
    x = v;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int from_bcd(input logic [15:0] v);
    int r;
    r = 0;
    for (int i = 3; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  // Reference: {err, cout, sum}. Valid operands use plain decimal arithmetic;
  // operands with bad nibbles fall back to the per-digit rule.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic ci, input logic sb);
    logic bad;
    int tot, c, t, bd;
    logic [15:0] s;
    bad = 1'b0;
    for (int i = 0; i < 4; i++)
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) bad = 1'b1;
    if (!bad) begin
      if (sb) tot = from_bcd(a) - from_bcd(b) + 10000;
      else    tot = from_bcd(a) + from_bcd(b) + int'(ci);
      return {1'b0, tot >= 10000, to_bcd(tot % 10000)};
    end
    c = sb ? 1 : int'(ci);
    s = '0;
    for (int i = 0; i < 4; i++) begin
      bd = sb ? ((9 - int'(b[4*i +: 4])) & 15) : int'(b[4*i +: 4]);
      t  = int'(a[4*i +: 4]) + bd + c;
      if (t > 9) begin s[4*i +: 4] = 4'((t + 6) & 15); c = 1; end
      else       begin s[4*i +: 4] = 4'(t);            c = 0; end
    end
    return {1'b1, c[0], s};
  endfunction

  // One full transaction; hold = cycles out_ready stays low once out_valid is seen.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic ci,
                       input logic sb, input int hold,
                       output logic [15:0] s, output logic co, output logic er, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    check("wait_in_ready", in_ready, 1'b1);
    op_a = a; op_b = b; cin = ci; in_valid = 1'b1;
`ifdef BCD_SUB_EN
    sub = sb;
`else
    if (sb) $display("note: sub request ignored in add-only build");
`endif
    @(posedge clk); #1;
    in_valid = 1'b0;
    op_a = 16'($urandom); op_b = 16'($urandom); cin = 1'($urandom);
    check("in_ready_after_accept", in_ready, 1'b0);
    check("busy_after_accept", busy, 1'b1);
    lat = 0;
    while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    check("wait_out_valid", out_valid, 1'b1);
    s = sum; co = cout; er = err;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold_out_valid", out_valid, 1'b1);
      check("hold_sum", sum, s);
      check("hold_cout", cout, co);
      check("hold_in_ready", in_ready, 1'b0);
      check("hold_busy", busy, 1'b1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_hs_in_ready", in_ready, 1'b1);
    check("post_hs_out_valid", out_valid, 1'b0);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic [15:0] s;
    logic        co;
    logic        er;
  } vec_t;

  initial begin
    vec_t vt[6];
    logic [15:0] s;
    logic co, er, sb;
    logic [17:0] exp;
    int lat;

    vt[0] = '{16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0};
    vt[1] = '{16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vt[2] = '{16'h0999, 16'h0001, 1'b1, 16'h1001, 1'b0, 1'b0};
    vt[3] = '{16'h00A0, 16'h0000, 1'b0, 16'h0100, 1'b0, 1'b1};
    vt[4] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vt[5] = '{16'h000F, 16'h000F, 1'b1, 16'h0015, 1'b0, 1'b1};

    // Reset values, then in_ready rises on the first edge after release.
    #2;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_sum", sum, 16'h0000);
    check("rst_cout", cout, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_busy", busy, 1'b0);
    #10 rst_n = 1'b1;
    #1 check("in_ready_before_edge", in_ready, 1'b0);
    @(posedge clk); #1;
    check("in_ready_first_edge", in_ready, 1'b1);

    for (int i = 0; i < 6; i++) begin
      do_op(vt[i].a, vt[i].b, vt[i].ci, 1'b0, 0, s, co, er, lat);
      check($sformatf("vec%0d_sum", i), s, vt[i].s);
      check($sformatf("vec%0d_cout", i), co, vt[i].co);
      check($sformatf("vec%0d_err", i), er, vt[i].er);
      check($sformatf("vec%0d_latency", i), lat, 5);
    end

    // Backpressure: result held for 5 cycles with out_ready low.
    do_op(16'h1234, 16'h5678, 1'b0, 1'b0, 5, s, co, er, lat);
    check("bp_sum", s, 16'h6912);
    check("bp_cout", co, 1'b0);

    // Reset two cycles into RUN: outputs clear asynchronously.
    @(posedge clk); #1;
    op_a = 16'h4444; op_b = 16'h5555; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 1'b0);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_sum", sum, 16'h0000);
    check("midrst_cout", cout, 1'b0);
    check("midrst_err", err, 1'b0);
    check("midrst_busy", busy, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_in_ready_back", in_ready, 1'b1);
    do_op(16'h0005, 16'h0005, 1'b0, 1'b0, 0, s, co, er, lat);
    check("after_rst_sum", s, 16'h0010);
    check("after_rst_cout", co, 1'b0);
    check("after_rst_err", er, 1'b0);

`ifdef BCD_SUB_EN
    do_op(16'h5000, 16'h1234, 1'b0, 1'b1, 0, s, co, er, lat);
    check("sub1_sum", s, 16'h3766);
    check("sub1_cout", co, 1'b1);
    do_op(16'h1234, 16'h5000, 1'b1, 1'b1, 0, s, co, er, lat);
    check("sub2_sum", s, 16'h6234);
    check("sub2_cout", co, 1'b0);
`endif

    // Random operations against the reference model.
    for (int r = 0; r < 150; r++) begin
      logic [15:0] ra, rb;
      logic rc;
      if ($urandom_range(0, 3) == 0) begin
        ra = 16'($urandom); rb = 16'($urandom);
      end else begin
        ra = to_bcd(int'($urandom_range(0, 9999)));
        rb = to_bcd(int'($urandom_range(0, 9999)));
      end
      rc = 1'($urandom);
`ifdef BCD_SUB_EN
      sb = 1'($urandom);
`else
      sb = 1'b0;
`endif
      exp = model(ra, rb, rc, sb);
      do_op(ra, rb, rc, sb, int'($urandom_range(0, 2)), s, co, er, lat);
      check($sformatf("rnd%0d_sum a=%h b=%h", r, ra, rb), s, exp[15:0]);
      check($sformatf("rnd%0d_cout", r), co, exp[16]);
      check($sformatf("rnd%0d_err", r), er, exp[17]);
      check($sformatf("rnd%0d_latency", r), lat, 5);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, fails);
    $finish;
  end

endmodule
